regfile_access_ctrl: RTL and testbench
======================================

Name: regfile_access_ctrl

Overview:
- Initiator/sequencer that drives the 2-entry x 8-bit register file port (rd, rs, regWrite, writeData) and collects its outData0/outData1.
- Accepts operand-read requests from decode and result-write requests from execute via valid/ready handshakes.
- Buffers writes in a small FIFO and serialises all register file traffic through one FSM, so the register file never sees a read and a write in the same cycle.

Parameters:
- DATA_W, 8, register data width.
- ADDR_W, 1, register address width (2 registers).
- WBUF_DEPTH, 2, write-buffer entries; power of 2, >= 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rd_req_valid  in  1  operand-read request valid.
- rd_req_ready  out  1  read request accepted when valid&&ready.
- rd_req_rd  in  ADDR_W  register returned on rd_rsp_data1.
- rd_req_rs  in  ADDR_W  register returned on rd_rsp_data0.
- rd_rsp_valid  out  1  one-cycle pulse: response data valid.
- rd_rsp_data0  out  DATA_W  value of register rs.
- rd_rsp_data1  out  DATA_W  value of register rd.
- wr_req_valid  in  1  write request valid.
- wr_req_ready  out  1  write-buffer space available.
- wr_req_addr  in  ADDR_W  destination register.
- wr_req_data  in  DATA_W  write data.
- rf_rd  out  ADDR_W  to register file rd.
- rf_rs  out  ADDR_W  to register file rs.
- rf_regWrite  out  1  to register file regWrite.
- rf_writeData  out  DATA_W  to register file writeData.
- rf_outData0  in  DATA_W  from register file (rs value).
- rf_outData1  in  DATA_W  from register file (rd value).
- wbuf_count  out  $clog2(WBUF_DEPTH)+1  current write-buffer occupancy.

Behaviour:
- Reset (async, rst_n=0):
  - FSM goes to IDLE and the FIFO is emptied; pending writes are discarded.
  - All outputs go to 0, except wr_req_ready, which goes to 1 once rst_n=1.
- Write buffer:
  - Push on wr_req_valid&&wr_req_ready.
  - wr_req_ready = (wbuf_count < WBUF_DEPTH), taken from registered state; it is low when full, with no bypass.
  - Push and pop in the same cycle are allowed when not full; count is unchanged.
  - Pointers wrap modulo WBUF_DEPTH.
- FSM states: IDLE, WRITE, READ, RESP. All rf_* outputs are registered.
- IDLE:
  - FIFO non-empty -> WRITE. Pop the head; the next cycle drives rf_regWrite=1, rf_rd=head.addr, rf_writeData=head.data.
  - Else if read handshake -> READ. The next cycle drives rf_regWrite=0, rf_rd=rd_req_rd, rf_rs=rd_req_rs.
- WRITE:
  - Exactly one cycle per entry.
  - If the FIFO is still non-empty, pop the next entry and stay in WRITE; else go to IDLE with rf_regWrite=0.
- READ: one cycle with addresses stable and regWrite low -> RESP.
- RESP:
  - Sample rf_outData0/1 into rd_rsp_data0/1 and pulse rd_rsp_valid for one cycle -> IDLE.
  - rd_rsp_data holds its value until the next response.
- rd_req_ready = (state==IDLE) && (wbuf_count==0). Reads wait for all buffered writes to drain, which guarantees read-after-write ordering.
- Latency:
  - Read: handshake at cycle N, rd_rsp_valid at cycle N+2.
  - Write: handshake at N, rf_regWrite high no earlier than N+2 (earliest when IDLE with empty FIFO).
- rf_rd/rf_rs/rf_writeData hold their last values in IDLE and RESP.
- rf_regWrite is never high in READ or RESP.
- Simultaneous read and write request in IDLE with an empty FIFO: the write is pushed and the read is accepted. The read is issued first; the write drains after RESP, so the read returns the old value.
- Reset mid-operation: an in-flight read produces no response, and a partial write is abandoned.

Optional Feature:
- Macro: RF_FWD_EN.
- Defined:
  - rd_req_ready = (state==IDLE); reads take priority over draining.
  - In RESP, each response field takes the data of the youngest FIFO entry whose addr matches rd (data1) or rs (data0); otherwise it takes the rf_outData value.
  - A write pushed in the same cycle as the read handshake is not forwarded.
- Undefined: reads wait for an empty FIFO as above, and there is no forwarding logic.

Test Plan:
- Reset, then check outputs: rf_regWrite=0, rd_rsp_valid=0, wbuf_count=0, wr_req_ready=1.
- Write r0=0xA5, r1=0x3C, then read rd=1, rs=0 -> rd_rsp_data1=0x3C, rd_rsp_data0=0xA5; rd_rsp_valid pulses exactly 2 cycles after the read handshake.
- Three back-to-back writes with WBUF_DEPTH=2 while FSM busy:
  - wr_req_ready drops at count=2.
  - rf_regWrite stays high for consecutive cycles, and register file contents equal the last write per address.
- Write r1=0x77, then present a read of rd=1 the next cycle:
  - Without RF_FWD_EN: rd_req_ready stays low until drained, then data1=0x77.
  - With RF_FWD_EN: the read is accepted immediately and data1=0x77 via forwarding.
- Assert rst_n=0 mid-READ and mid-WRITE drain -> no rd_rsp_valid, wbuf_count=0, rf_regWrite=0 immediately (async).
- Fill the FIFO to 2, then push and pop in the same cycle after one entry drains -> count stays 1 and no entry is lost or duplicated.

Source files
------------

// File: rtl/regfile_access_ctrl.sv
// Sequencer for a 2-port register file: buffers execute writes in a FIFO and serialises them
// with decode operand reads through one FSM. Define RF_FWD_EN to let reads bypass buffered writes.
module regfile_access_ctrl #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned ADDR_W     = 1,
  parameter int unsigned WBUF_DEPTH = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        rd_req_valid,
  output logic                        rd_req_ready,
  input  logic [ADDR_W-1:0]           rd_req_rd,
  input  logic [ADDR_W-1:0]           rd_req_rs,
  output logic                        rd_rsp_valid,
  output logic [DATA_W-1:0]           rd_rsp_data0,
  output logic [DATA_W-1:0]           rd_rsp_data1,
  input  logic                        wr_req_valid,
  output logic                        wr_req_ready,
  input  logic [ADDR_W-1:0]           wr_req_addr,
  input  logic [DATA_W-1:0]           wr_req_data,
  output logic [ADDR_W-1:0]           rf_rd,
  output logic [ADDR_W-1:0]           rf_rs,
  output logic                        rf_regWrite,
  output logic [DATA_W-1:0]           rf_writeData,
  input  logic [DATA_W-1:0]           rf_outData0,
  input  logic [DATA_W-1:0]           rf_outData1,
  output logic [$clog2(WBUF_DEPTH):0] wbuf_count
);

  localparam int unsigned PTR_W = $clog2(WBUF_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;

  state_t             state_q;
  logic [ADDR_W-1:0]  mem_addr_q [WBUF_DEPTH];
  logic [DATA_W-1:0]  mem_data_q [WBUF_DEPTH];
  logic [PTR_W-1:0]   wptr_q, wptr_d;
  logic [PTR_W-1:0]   rptr_q, rptr_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic [ADDR_W-1:0]  rf_rd_q, rf_rs_q;
  logic               rf_regWrite_q;
  logic [DATA_W-1:0]  rf_writeData_q;
  logic               rsp_valid_q;
  logic [DATA_W-1:0]  rsp_data0_q, rsp_data1_q;
  logic [DATA_W-1:0]  rsp0_d, rsp1_d;

  logic push, pop, rd_fire, has_data;

  assign has_data     = (count_q != '0);
  assign wr_req_ready = rst_n && (count_q < CNT_W'(WBUF_DEPTH));
`ifdef RF_FWD_EN
  assign rd_req_ready = rst_n && (state_q == IDLE);
`else
  assign rd_req_ready = rst_n && (state_q == IDLE) && !has_data;
`endif
  assign push    = wr_req_valid && wr_req_ready;
  assign rd_fire = rd_req_valid && rd_req_ready;
  // A read handshake in IDLE wins over draining; without forwarding it implies an empty buffer.
  assign pop     = has_data && (((state_q == IDLE) && !rd_fire) || (state_q == WRITE));

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push) wptr_d = wptr_q + 1'b1;
    if (pop)  rptr_d = rptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr_q[wptr_q] <= wr_req_addr;
      mem_data_q[wptr_q] <= wr_req_data;
    end
  end

`ifdef RF_FWD_EN
  logic [CNT_W-1:0] fwd_cnt_q;
  logic [PTR_W-1:0] fwd_idx;

  // Only entries present at the read handshake are eligible; later entries override earlier ones.
  always_comb begin
    rsp0_d  = rf_outData0;
    rsp1_d  = rf_outData1;
    fwd_idx = '0;
    for (int unsigned i = 0; i < WBUF_DEPTH; i++) begin
      fwd_idx = rptr_q + PTR_W'(i);
      if (CNT_W'(i) < fwd_cnt_q) begin
        if (mem_addr_q[fwd_idx] == rf_rs_q) rsp0_d = mem_data_q[fwd_idx];
        if (mem_addr_q[fwd_idx] == rf_rd_q) rsp1_d = mem_data_q[fwd_idx];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       fwd_cnt_q <= '0;
    else if (rd_fire) fwd_cnt_q <= count_q;
  end
`else
  always_comb begin
    rsp0_d = rf_outData0;
    rsp1_d = rf_outData1;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      rf_rd_q        <= '0;
      rf_rs_q        <= '0;
      rf_regWrite_q  <= 1'b0;
      rf_writeData_q <= '0;
      rsp_valid_q    <= 1'b0;
      rsp_data0_q    <= '0;
      rsp_data1_q    <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (rd_fire) begin
            state_q       <= READ;
            rf_regWrite_q <= 1'b0;
            rf_rd_q       <= rd_req_rd;
            rf_rs_q       <= rd_req_rs;
          end else if (has_data) begin
            state_q        <= WRITE;
            rf_regWrite_q  <= 1'b1;
            rf_rd_q        <= mem_addr_q[rptr_q];
            rf_writeData_q <= mem_data_q[rptr_q];
          end
        end
        WRITE: begin
          if (has_data) begin
            rf_regWrite_q  <= 1'b1;
            rf_rd_q        <= mem_addr_q[rptr_q];
            rf_writeData_q <= mem_data_q[rptr_q];
          end else begin
            state_q       <= IDLE;
            rf_regWrite_q <= 1'b0;
          end
        end
        // Register file data is sampled at the end of READ so the pulse lands in RESP.
        READ: begin
          state_q     <= RESP;
          rsp_valid_q <= 1'b1;
          rsp_data0_q <= rsp0_d;
          rsp_data1_q <= rsp1_d;
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rf_rd        = rf_rd_q;
  assign rf_rs        = rf_rs_q;
  assign rf_regWrite  = rf_regWrite_q;
  assign rf_writeData = rf_writeData_q;
  assign rd_rsp_valid = rsp_valid_q;
  assign rd_rsp_data0 = rsp_data0_q;
  assign rd_rsp_data1 = rsp_data1_q;
  assign wbuf_count   = count_q;

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Bench for regfile_access_ctrl: attached register file, architectural-state model and directed tests.
module tb_regfile_access_ctrl;

  localparam int DEPTH = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rd_req_valid = 1'b0, rd_req_ready;
  logic       rd_req_rd = 1'b0, rd_req_rs = 1'b0;
  logic       rd_rsp_valid;
  logic [7:0] rd_rsp_data0, rd_rsp_data1;
  logic       wr_req_valid = 1'b0, wr_req_ready;
  logic       wr_req_addr = 1'b0;
  logic [7:0] wr_req_data = 8'h00;
  logic       rf_rd, rf_rs, rf_regWrite;
  logic [7:0] rf_writeData, rf_outData0, rf_outData1;
  logic [1:0] wbuf_count;

  regfile_access_ctrl #(.DATA_W(8), .ADDR_W(1), .WBUF_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
    .rd_req_rd(rd_req_rd), .rd_req_rs(rd_req_rs),
    .rd_rsp_valid(rd_rsp_valid), .rd_rsp_data0(rd_rsp_data0), .rd_rsp_data1(rd_rsp_data1),
    .wr_req_valid(wr_req_valid), .wr_req_ready(wr_req_ready),
    .wr_req_addr(wr_req_addr), .wr_req_data(wr_req_data),
    .rf_rd(rf_rd), .rf_rs(rf_rs), .rf_regWrite(rf_regWrite), .rf_writeData(rf_writeData),
    .rf_outData0(rf_outData0), .rf_outData1(rf_outData1),
    .wbuf_count(wbuf_count)
  );

  always #5 clk = ~clk;

  // Attached register file: combinational read, write on rising edge.
  logic [7:0] rf [2] = '{8'h00, 8'h00};
  assign rf_outData0 = rf[rf_rs];
  assign rf_outData1 = rf[rf_rd];
  always @(posedge clk) if (rf_regWrite) rf[rf_rd] <= rf_writeData;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: architectural register values as seen by program order of accepted requests,
  // the ordered list of writes still owed to the register file, and pending responses.
  typedef struct { logic a; logic [7:0] d; } wr_t;
  typedef struct { int due; logic [7:0] d0; logic [7:0] d1; } rsp_t;
  wr_t        wq[$];
  rsp_t       rq[$];
  logic [7:0] arch [2] = '{8'h00, 8'h00};
  int         rsp_cnt = 0, last_cyc = 0, wr_run = 0, max_run = 0;
  logic [7:0] last0 = 8'h00, last1 = 8'h00;

  always @(negedge clk) begin
    wr_t  w;
    rsp_t r;
    bit   due;
    if (!rst_n) begin
      wq.delete();
      rq.delete();
      arch[0] = rf[0];
      arch[1] = rf[1];
      wr_run = 0;
    end else begin
      if (rf_regWrite) begin
        wr_run++;
        if (wr_run > max_run) max_run = wr_run;
        chk("rf_write_owed", wq.size() != 0, 1);
        if (wq.size() != 0) begin
          w = wq.pop_front();
          chk("rf_write_addr", rf_rd, w.a);
          chk("rf_write_data", rf_writeData, w.d);
        end
        chk("rf_write_in_read", rq.size() != 0 && (rq[0].due == cyc || rq[0].due == cyc + 1), 0);
      end else begin
        wr_run = 0;
      end
      chk("wbuf_count", wbuf_count, wq.size());
      chk("wr_req_ready", wr_req_ready, wq.size() < DEPTH);
      due = rq.size() != 0 && rq[0].due == cyc;
      if (rd_rsp_valid || due) begin
        chk("rsp_valid_timing", rd_rsp_valid, due);
        if (due) begin
          r = rq.pop_front();
          if (rd_rsp_valid) begin
            chk("rsp_data0", rd_rsp_data0, r.d0);
            chk("rsp_data1", rd_rsp_data1, r.d1);
          end
        end
      end
      if (rd_rsp_valid) begin
        rsp_cnt++;
        last0 = rd_rsp_data0;
        last1 = rd_rsp_data1;
        last_cyc = cyc;
      end
      // Handshakes completing at the coming edge; a read sees state before a same-cycle write.
      if (rd_req_valid && rd_req_ready) begin
        r.due = cyc + 2;
        r.d0 = arch[rd_req_rs];
        r.d1 = arch[rd_req_rd];
        rq.push_back(r);
      end
      if (wr_req_valid && wr_req_ready) begin
        w.a = wr_req_addr;
        w.d = wr_req_data;
        wq.push_back(w);
        arch[wr_req_addr] = wr_req_data;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic a, input logic [7:0] d);
    bit ok = 0;
    wr_req_valid = 1'b1; wr_req_addr = a; wr_req_data = d;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk); #1;
      if (wr_req_ready) begin ok = 1; break; end
    end
    chk("wr_accept", ok, 1);
    tick();
    wr_req_valid = 1'b0;
  endtask

  task automatic do_read(input logic rdx, input logic rsx, output int hs, output int waits);
    bit ok = 0;
    hs = -1; waits = 0;
    rd_req_valid = 1'b1; rd_req_rd = rdx; rd_req_rs = rsx;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk); #1;
      if (rd_req_ready) begin ok = 1; hs = cyc; break; end
      waits++;
    end
    chk("rd_accept", ok, 1);
    tick();
    rd_req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int n);
    bit ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (rsp_cnt > n) begin ok = 1; break; end
    end
    chk("rsp_arrived", ok, 1);
  endtask

  task automatic wait_drain();
    bit ok = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (wbuf_count == 2'd0 && !rf_regWrite && rq.size() == 0) begin ok = 1; break; end
    end
    chk("drained", ok, 1);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    int hs, waits, n;
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_regWrite", rf_regWrite, 0);
    chk("rst_rsp_valid", rd_rsp_valid, 0);
    chk("rst_count", wbuf_count, 0);
    @(negedge clk); #2 rst_n = 1'b1;
    @(negedge clk); #1;
    chk("post_rst_wr_ready", wr_req_ready, 1);
    chk("post_rst_count", wbuf_count, 0);
    chk("post_rst_regWrite", rf_regWrite, 0);
    chk("post_rst_rsp_valid", rd_rsp_valid, 0);
    tick();

    // Two writes then a read of both registers
    do_write(1'b0, 8'hA5);
    do_write(1'b1, 8'h3C);
    n = rsp_cnt;
    do_read(1'b1, 1'b0, hs, waits);
    wait_rsp(n);
    chk("basic_data1", last1, 8'h3C);
    chk("basic_data0", last0, 8'hA5);
    chk("basic_latency", last_cyc - hs, 2);
    wait_drain();

    // Writes pile up behind a read: fill, then push and pop in the same cycle
    n = rsp_cnt;
    do_read(1'b1, 1'b0, hs, waits);
    do_write(1'b0, 8'h11);
    do_write(1'b1, 8'h22);
    chk("full_count", wbuf_count, 2);
    chk("full_wr_ready", wr_req_ready, 0);
    do_write(1'b0, 8'h33);
    chk("pushpop_count", wbuf_count, 1);
    wait_rsp(n);
    chk("busy_data1", last1, 8'h3C);
    chk("busy_data0", last0, 8'hA5);
    wait_drain();
    chk("burst_run", max_run, 3);
    chk("rf0_last", rf[0], 8'h33);
    chk("rf1_last", rf[1], 8'h22);

    // Read right after a write to the same register
    do_write(1'b1, 8'h77);
    n = rsp_cnt;
    do_read(1'b1, 1'b0, hs, waits);
`ifdef RF_FWD_EN
    chk("raw_wait", waits, 0);
`else
    chk("raw_wait", waits, 2);
`endif
    wait_rsp(n);
    chk("raw_data1", last1, 8'h77);
    chk("raw_data0", last0, 8'h33);
    wait_drain();

    // Simultaneous read and write: read returns the old value
    n = rsp_cnt;
    wr_req_valid = 1'b1; wr_req_addr = 1'b0; wr_req_data = 8'h5A;
    rd_req_valid = 1'b1; rd_req_rd = 1'b0; rd_req_rs = 1'b1;
    @(negedge clk); #1;
    chk("sim_rd_ready", rd_req_ready, 1);
    chk("sim_wr_ready", wr_req_ready, 1);
    tick();
    wr_req_valid = 1'b0; rd_req_valid = 1'b0;
    wait_rsp(n);
    chk("sim_data1", last1, 8'h33);
    chk("sim_data0", last0, 8'h77);
    wait_drain();
    chk("sim_rf0", rf[0], 8'h5A);

    // Reset during READ
    n = rsp_cnt;
    do_read(1'b0, 1'b1, hs, waits);
    rst_n = 1'b0;
    #1;
    chk("rstrd_regWrite", rf_regWrite, 0);
    chk("rstrd_rsp_valid", rd_rsp_valid, 0);
    chk("rstrd_count", wbuf_count, 0);
    chk("rstrd_rd_ready", rd_req_ready, 0);
    @(negedge clk); #2 rst_n = 1'b1;
    repeat (5) tick();
    chk("rstrd_no_rsp", rsp_cnt, n);

    // Reset during a write drain
    do_write(1'b0, 8'hC1);
    do_write(1'b1, 8'hC2);
    begin
      bit seen = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk); #1;
        if (rf_regWrite) begin seen = 1; break; end
      end
      chk("rstwr_drain_started", seen, 1);
    end
    chk("rstwr_pre_count", wbuf_count, 1);
    rst_n = 1'b0;
    #1;
    chk("rstwr_regWrite", rf_regWrite, 0);
    chk("rstwr_count", wbuf_count, 0);
    @(negedge clk); #2 rst_n = 1'b1;
    repeat (5) tick();
    chk("rstwr_rf0", rf[0], 8'h5A);
    chk("rstwr_rf1", rf[1], 8'h77);
    chk("rstwr_wr_ready", wr_req_ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
